// File: rtl/conv3d_pkg.sv
// Shared widths, the packed output word and the requantization helpers for the conv3d output packer.
package conv3d_pkg;

  localparam int CONV_IN_W       = 12;
  localparam int CONV_OUT_W      = 8;
  localparam int CONV_PACK       = 4;
  localparam int CONV_SHIFT      = 2;
  localparam int CONV_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [CONV_PACK*CONV_OUT_W-1:0] data;
    logic [CONV_PACK-1:0]            keep;
    logic                            last;
  } word_t;

  localparam logic [CONV_IN_W:0] SAT_MAX = (CONV_IN_W+1)'((1 << CONV_OUT_W) - 1);

  // One extra bit keeps the rounding carry of a full-scale voxel.
  function automatic logic [CONV_IN_W:0] requant_raw(input logic [CONV_IN_W-1:0] voxel,
                                                     input int unsigned shift);
    logic [CONV_IN_W:0] rnd;
    rnd = '0;
    if (shift > 0) rnd = (CONV_IN_W+1)'(1) << (shift - 1);
    return ({1'b0, voxel} + rnd) >> shift;
  endfunction

  function automatic logic requant_is_sat(input logic [CONV_IN_W-1:0] voxel,
                                          input int unsigned shift);
    return requant_raw(voxel, shift) > SAT_MAX;
  endfunction

  function automatic logic [CONV_OUT_W-1:0] requant_sat(input logic [CONV_IN_W-1:0] voxel,
                                                        input int unsigned shift);
    logic [CONV_IN_W:0] raw;
    raw = requant_raw(voxel, shift);
    return (raw > SAT_MAX) ? '1 : raw[CONV_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv3d_out_packer_if.sv
// Voxel stream in and packed-word ready/valid stream out; master is the packer side.
interface conv3d_out_packer_if #(
  parameter int IN_W  = conv3d_pkg::CONV_IN_W,
  parameter int OUT_W = conv3d_pkg::CONV_OUT_W,
  parameter int PACK  = conv3d_pkg::CONV_PACK
);
  logic [IN_W-1:0]       voxel_in;
  logic                  valid_in;
  logic                  last_in;
  logic [PACK*OUT_W-1:0] out_data;
  logic [PACK-1:0]       out_keep;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  voxel_in, valid_in, last_in, out_ready,
    output out_data, out_keep, out_last, out_valid
  );

  modport slave (
    output voxel_in, valid_in, last_in, out_ready,
    input  out_data, out_keep, out_last, out_valid
  );
endinterface

// File: rtl/conv3d_word_fifo.sv
// Word FIFO, registered write / combinational head; a push while full without a pop is dropped and flagged.
module conv3d_word_fifo
  import conv3d_pkg::*;
#(
  parameter int DEPTH = CONV_FIFO_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  word_t push_word,
  input  logic  pop,
  output word_t head,
  output logic  empty,
  output logic  full,
  output logic  drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;
  word_t       mem_q [DEPTH];

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    push_ok  = push && (!full || pop_ok);
    drop     = push && !push_ok;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    head     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

endmodule

// File: rtl/conv3d_out_packer.sv
// Requantize, pack PACK voxels per word, buffer and emit on ready/valid; 2-cycle latency into an empty FIFO.
// No upstream backpressure: words arriving at a full FIFO are dropped (sticky overflow); CONV3D_PACK_SAT_CNT_EN adds sat_count.
module conv3d_out_packer
  import conv3d_pkg::*;
#(
  parameter int          IN_W       = CONV_IN_W,
  parameter int          OUT_W      = CONV_OUT_W,
  parameter int unsigned SHIFT      = CONV_SHIFT,
  parameter int          PACK       = CONV_PACK,
  parameter int          FIFO_DEPTH = CONV_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  conv3d_out_packer_if.master bus,
  output logic done,
  output logic overflow
`ifdef CONV3D_PACK_SAT_CNT_EN
  ,
  output logic [15:0] sat_count
`endif
);
  // Word layout is fixed by word_t, so OUT_W/PACK/IN_W must match the package widths.
  localparam int LCW = $clog2(PACK);

  logic                  s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_sat_q, s1_sat_d;
  logic [OUT_W-1:0]      s1_dat_q, s1_dat_d;
  logic [LCW-1:0]        lane_cnt_q, lane_cnt_d;
  logic [PACK*OUT_W-1:0] data_q, data_d, word_data;
  logic [PACK-1:0]       keep_q, keep_d, word_keep;
  logic                  done_q, done_d, overflow_q, overflow_d;
  logic                  push, pop, empty, full, drop;
  word_t                 push_word, head;
`ifdef CONV3D_PACK_SAT_CNT_EN
  logic [15:0]           sat_cnt_q, sat_cnt_d, sat_base;
  logic                  after_last_q, after_last_d;
`endif

  always_comb begin
    s1_vld_d   = bus.valid_in;
    s1_dat_d   = s1_dat_q;
    s1_last_d  = s1_last_q;
    s1_sat_d   = s1_sat_q;
    if (bus.valid_in) begin
      s1_dat_d  = requant_sat(CONV_IN_W'(bus.voxel_in), SHIFT);
      s1_sat_d  = requant_is_sat(CONV_IN_W'(bus.voxel_in), SHIFT);
      s1_last_d = bus.last_in;
    end

    word_data = data_q;
    word_keep = keep_q;
    word_data[lane_cnt_q*OUT_W +: OUT_W] = s1_dat_q;
    word_keep[lane_cnt_q] = 1'b1;

    lane_cnt_d = lane_cnt_q;
    data_d     = data_q;
    keep_d     = keep_q;
    push       = 1'b0;
    push_word  = '0;
    if (s1_vld_q) begin
      if (lane_cnt_q == LCW'(PACK - 1) || s1_last_q) begin
        push       = 1'b1;
        push_word  = '{data: word_data, keep: word_keep, last: s1_last_q};
        lane_cnt_d = '0;
        data_d     = '0;
        keep_d     = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + 1'b1;
        data_d     = word_data;
        keep_d     = word_keep;
      end
    end

    pop        = !empty && bus.out_ready;
    done_d     = pop && head.last;
    overflow_d = overflow_q | (drop & full);

`ifdef CONV3D_PACK_SAT_CNT_EN
    // The first voxel after a frame's last starts the count afresh.
    sat_base     = after_last_q ? 16'd0 : sat_cnt_q;
    sat_cnt_d    = sat_cnt_q;
    after_last_d = after_last_q;
    if (s1_vld_q) begin
      sat_cnt_d    = (s1_sat_q && sat_base != 16'hFFFF) ? sat_base + 16'd1 : sat_base;
      after_last_d = s1_last_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_dat_q     <= '0;
      s1_last_q    <= 1'b0;
      s1_sat_q     <= 1'b0;
      lane_cnt_q   <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef CONV3D_PACK_SAT_CNT_EN
      sat_cnt_q    <= '0;
      after_last_q <= 1'b0;
`endif
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_dat_q     <= s1_dat_d;
      s1_last_q    <= s1_last_d;
      s1_sat_q     <= s1_sat_d;
      lane_cnt_q   <= lane_cnt_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
`ifdef CONV3D_PACK_SAT_CNT_EN
      sat_cnt_q    <= sat_cnt_d;
      after_last_q <= after_last_d;
`endif
    end
  end

  conv3d_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .drop      (drop)
  );

  assign bus.out_data  = head.data;
  assign bus.out_keep  = head.keep;
  assign bus.out_last  = head.last;
  assign bus.out_valid = !empty;
  assign done          = done_q;
  assign overflow      = overflow_q;
`ifdef CONV3D_PACK_SAT_CNT_EN
  assign sat_count     = sat_cnt_q;
`endif

endmodule

// File: tb/tb_conv3d_out_packer.sv
// Directed bench for conv3d_out_packer with a word scoreboard and done-pulse timing checks.
module tb_conv3d_out_packer;
  localparam int IN_W = 12, OUT_W = 8, PACK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done, overflow;
`ifdef CONV3D_PACK_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  conv3d_out_packer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .PACK(PACK)) bus ();

  conv3d_out_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(2), .PACK(PACK), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .done      (done),
    .overflow  (overflow)
`ifdef CONV3D_PACK_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  int obs_rd = 0;
  int cyc = 0;
  int lhs_q[$];
  int done_q[$];
  int m_cnt = 0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_keep = '0;

  // Monitor: records every accepted word and every done cycle, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back({bus.out_data, bus.out_keep, bus.out_last});
        if (bus.out_last) lhs_q.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
    end
  end

  function automatic int req(input int v);
    int r;
    r = (v + 2) / 4;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input logic last);
    bus.voxel_in = 12'(v);
    bus.valid_in = 1'b1;
    bus.last_in  = last;
    m_data[m_cnt*8 +: 8] = 8'(req(v));
    m_keep[m_cnt] = 1'b1;
    if (m_cnt == 3 || last) begin
      exp_q.push_back({m_data, m_keep, last});
      m_cnt = 0; m_data = '0; m_keep = '0;
    end else begin
      m_cnt++;
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0; m_data = '0; m_keep = '0;
    obs_rd = obs_q.size();
  endtask

  task automatic drain_check(input string tag);
    int n;
    int want;
    n = 0;
    want = exp_q.size();
    while ((obs_q.size() - obs_rd) < want && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(obs_q.size() - obs_rd), 64'(want));
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      check({tag, "_word"}, 64'(obs_q[obs_rd]), 64'(exp_q.pop_front()));
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    bus.voxel_in = '0; bus.valid_in = 1'b0; bus.last_in = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(bus.out_valid), 64'(0));
    check("reset_data", 64'(bus.out_data), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Requantization incl. saturation: 25, 255, 0, 1.
    bus.out_ready = 1'b1;
    send(100, 1'b0); send(4095, 1'b0); send(1, 1'b0); send(2, 1'b0);
    drain_check("requant");
`ifdef CONV3D_PACK_SAT_CNT_EN
    check("sat_count_one", 64'(sat_count), 64'(1));
`endif

    // Packing and two-cycle latency.
    send(4, 1'b0); send(8, 1'b0); send(12, 1'b0); send(16, 1'b0);
    check("lat1_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    check("lat2_valid", 64'(bus.out_valid), 64'(1));
    check("lat2_data", 64'(bus.out_data), 64'(32'h04030201));
    check("lat2_keep", 64'(bus.out_keep), 64'(4'b1111));
    check("lat2_last", 64'(bus.out_last), 64'(0));
    drain_check("pack");

    // Partial flush on last, then back-to-back single-voxel frames.
    repeat (4) send(40, 1'b0);
    send(40, 1'b1);
    drain_check("flush");
`ifdef CONV3D_PACK_SAT_CNT_EN
    check("sat_count_hold", 64'(sat_count), 64'(1));
`endif
    send(8, 1'b1); send(12, 1'b1);
    drain_check("b2b");
`ifdef CONV3D_PACK_SAT_CNT_EN
    check("sat_count_clear", 64'(sat_count), 64'(0));
`endif

    // Backpressure: 6 words into a 4-deep FIFO, the last two dropped.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(4*i, 1'b0);
    @(posedge clk); #1;
    check("ovf_before", 64'(overflow), 64'(0));
    check("ovf_held_valid", 64'(bus.out_valid), 64'(1));
    for (int i = 17; i <= 20; i++) send(4*i, 1'b0);
    @(posedge clk); #1;
    check("ovf_after", 64'(overflow), 64'(1));
    for (int i = 21; i <= 24; i++) send(4*i, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    bus.out_ready = 1'b1;
    drain_check("ovf_drain");
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Asynchronous reset mid-frame with a word buffered.
    bus.out_ready = 1'b0;
    send(200, 1'b0); send(204, 1'b0); send(208, 1'b0); send(212, 1'b0);
    @(posedge clk); #1;
    check("rst_pre_valid", 64'(bus.out_valid), 64'(1));
    send(300, 1'b0); send(304, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_data", 64'(bus.out_data), 64'(0));
    check("rst_keep", 64'(bus.out_keep), 64'(0));
    check("rst_last", 64'(bus.out_last), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(60, 1'b0); send(64, 1'b0); send(68, 1'b0); send(72, 1'b0);
    drain_check("post_rst");

    // Full FIFO with push and pop on the same edge.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(4*i + 1, 1'b0);
    @(posedge clk); #1;
    check("full_valid", 64'(bus.out_valid), 64'(1));
    for (int i = 17; i <= 20; i++) send(4*i + 1, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("full_sim_pop", 64'(obs_q.size() - obs_rd), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    check("full_sim_ovf", 64'(overflow), 64'(0));
    bus.out_ready = 1'b1;
    drain_check("full_sim_drain");

    // done: one pulse per last-word handshake, exactly one cycle later.
    check("last_hs_count", 64'(lhs_q.size()), 64'(3));
    check("done_count", 64'(done_q.size()), 64'(lhs_q.size()));
    for (int i = 0; i < lhs_q.size() && i < done_q.size(); i++)
      check("done_timing", 64'(done_q[i]), 64'(lhs_q[i] + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/conv3d_out_packer.md
Name: conv3d_out_packer

Overview:
- Downstream stage of the conv3d core. Consumes its widened output stream (voxel, valid, done-as-last).
- Requantizes each voxel to OUT_W bits: round, shift right by SHIFT, saturate.
- Packs PACK results into one word and buffers words in a small FIFO.
- Presents the words on a ready/valid interface to the memory writer.

Parameters:
- IN_W, 12, input voxel width (conv3d DATA_W+4).
- OUT_W, 8, requantized voxel width.
- SHIFT, 2, right shift for requantization (0 allowed).
- PACK, 4, voxels per output word.
- FIFO_DEPTH, 4, output word FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- voxel_in  in  IN_W  unsigned voxel from conv3d.
- valid_in  in  1  voxel_in qualifier; no backpressure upstream.
- last_in  in  1  final voxel of frame (conv3d done); only meaningful with valid_in.
- out_data  out  PACK*OUT_W  packed word; lane 0 in the LSBs.
- out_keep  out  PACK  per-lane valid mask.
- out_last  out  1  word holds the frame's final voxel.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accept.
- done  out  1  one-cycle pulse after the last word is accepted.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (async, any time, including mid-frame):
  - All outputs go to 0.
  - FIFO is emptied, the lane counter is cleared, and any partial word is discarded.
- Stage 1 (1-cycle register), only when valid_in=1:
  - r = (voxel_in + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed in IN_W+1 bits so the carry is not lost.
  - If r > 2^OUT_W-1, the result is 2^OUT_W-1 (saturate).
  - last_in is carried alongside the data. A cycle with valid_in=0 produces no stage-1 valid, and its last_in is ignored.
- Stage 2 packing:
  - lane counter runs 0..PACK-1. Each stage-1 valid writes lane[lane_cnt] and sets keep[lane_cnt].
  - A word commits when lane_cnt==PACK-1 or when the voxel carries last.
  - On commit: push {data, keep, last} into the FIFO, then clear lane_cnt, the data register and the keep register. Unused lanes are zero.
  - A last on lane PACK-1 gives a full word with out_last=1. No extra empty word is emitted.
- Latency: a voxel completing a word is visible on out_data 2 cycles after its valid_in, provided the FIFO was empty.
- FIFO:
  - out_valid = !empty; out_* come from the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured, including when full (occupancy unchanged).
  - Push while full without a pop: the word is dropped, overflow is set and stays set until reset, and FIFO contents are unchanged.
  - Empty with out_ready high: nothing happens.
- done: registered. High for exactly 1 cycle following the handshake cycle of a word with out_last=1. Back-to-back frames give separate pulses.
- Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.

Optional Feature:
- Macro: CONV3D_PACK_SAT_CNT_EN.
- Defined:
  - Adds output sat_count (16 bits). It counts stage-1 voxels that saturated and holds at 0xFFFF (no wrap).
  - It clears on reset and at the start of the next frame (first valid voxel after a last).
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package conv3d_pkg:
  - width constants (IN_W default, OUT_W, PACK).
  - a packed word struct typedef {data, keep, last}.
  - function requant_sat(voxel, shift).
- One sub-module, conv3d_word_fifo: synchronous FIFO of word structs, parameterized by depth. It has full/empty flags and a push-when-full drop indicator, and uses the same asynchronous active-high reset.

Test Plan:
- Requant, SHIFT=2: inputs 100, 4095, 1, 2 -> stage-1 values 25, 255 (saturated), 0, 1.
- Packing: inputs 4, 8, 12, 16 on consecutive cycles with out_ready=1 -> one word out_data=0x04030201, keep=4'b1111, last=0, 2 cycles after the 4th valid.
- Partial flush: 5 voxels of value 40, the 5th with last_in=1 -> word0 0x0A0A0A0A keep 1111 last 0; then word1 0x0000000A keep 0001 last 1; done pulses once, 1 cycle after word1 is accepted.
- Backpressure/overflow: out_ready=0, 24 voxels -> 4 words held, overflow=1 after the 5th commit. Then out_ready=1 -> exactly the first 4 words drain, in order.
- Full plus simultaneous push/pop: FIFO full, out_ready=1 on the cycle a word commits -> no drop, overflow stays 0, occupancy stays 4.
- Reset mid-frame: rst pulsed asynchronously (between clock edges) after 2 voxels -> outputs 0 immediately. The next 4 voxels form a fresh word with lane 0 equal to the first post-reset voxel.
